instruction_fetch_controller: RTL
=================================

// Module: instruction_fetch_controller
// PURPOSE
//  Sequences the combinational InstructionMemory: owns the PC, drives Address, captures
//  Instruction into the IF/ID register with PC+4 and a valid bit. Handles pipeline stall,
//  branch/jump redirect with flush, end-of-memory wrap and a halt-word stop.
//  Sits between hazard/branch logic (ID/EX) and the IF/ID boundary of the MIPS pipeline.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset; must be word-aligned
//  IMEM_DEPTH  128            instruction memory size in 32-bit words; PC wraps at 4*IMEM_DEPTH
//  HALT_WORD   32'hFFFF_FFFF  instruction encoding that stops fetch
// PORTS
//  Clk            in   1   rising-edge clock
//  Rst            in   1   synchronous, active-low reset
//  Stall          in   1   hazard stall: hold PC and IF/ID contents
//  Redirect       in   1   branch taken / jump: load RedirectPC, flush IF/ID
//  RedirectPC     in   32  redirect target byte address
//  Address        out  32  byte address to InstructionMemory (= PC, combinational)
//  Instruction    in   32  read data from InstructionMemory (same-cycle, async read)
//  IF_Instruction out  32  IF/ID instruction register
//  IF_PCPlus4     out  32  IF/ID PC+4 register
//  IF_Valid       out  1   IF/ID register holds a real fetched instruction
//  Halted         out  1   fetch stopped on HALT_WORD
//  FetchCount     out  32  number of instructions latched with IF_Valid=1, saturating
// BEHAVIOUR
//  Reset (Rst==0 at posedge): PC=RESET_PC, IF_Instruction=0 (NOP), IF_PCPlus4=0, IF_Valid=0,
//   Halted=0, FetchCount=0, state=BOOT. Reset overrides all other inputs.
//  Address = PC at all times; one instruction fetched per cycle, IF/ID latency 1 cycle.
//  NextSeq = (PC+4 == 4*IMEM_DEPTH) ? 0 : PC+4   (wrap to word 0 at top of memory).
//  Redirect target: PC <= {RedirectPC[31:2],2'b00} (low bits forced 0), masked modulo 4*IMEM_DEPTH.
//  States: BOOT, RUN, STALL, HALT.
//   BOOT : one idle cycle after reset; IF_Valid=0; PC held; -> RUN.
//   RUN  : priority Redirect > Stall > normal.
//     Redirect: PC<=target; IF_Instruction<=0, IF_Valid<=0 (flush); stay RUN.
//     Stall   : PC, IF regs, FetchCount held; -> STALL.
//     normal  : IF_Instruction<=Instruction, IF_PCPlus4<=PC+4 (unwrapped value), IF_Valid<=1,
//               FetchCount++ ; if Instruction==HALT_WORD -> HALT, PC held; else PC<=NextSeq.
//   STALL: Redirect -> flush, PC<=target, -> RUN. Stall -> hold, stay. else -> RUN and
//          perform normal fetch of held PC in that same cycle (no instruction lost or duplicated).
//   HALT : Halted=1; PC held; IF_Valid<=0, IF_Instruction<=0 after the halt word drains.
//          Stall ignored. Redirect -> Halted<=0, PC<=target, -> RUN. Only Redirect or reset exit.
//  Simultaneous Stall+Redirect: redirect wins in every state.
//  FetchCount saturates at 32'hFFFF_FFFF; never increments on flush, stall, BOOT or HALT.
//  Reset asserted mid-stall/mid-halt: next cycle is BOOT with all reset values.
//  No combinational path from Stall/Redirect to Address; Address changes only at posedge.
// TESTING
//  1 Reset then free-run, mem[0..3]=A,B,C,D -> Address 0,0,4,8,12; IF_Instruction A,B,C
//    from cycle 2 with IF_PCPlus4 4,8,12; IF_Valid=1 from cycle 2; FetchCount=3 after C.
//  2 Stall high 3 cycles while PC=8 -> Address stays 8, IF regs hold B/8, FetchCount
//    frozen; on release C latched exactly once.
//  3 Redirect to 32'h0000_0022 while PC=12 -> next Address=32'h20, IF_Valid=0 one cycle,
//    then mem[8] latched with IF_PCPlus4=32'h24.
//  4 Stall and Redirect same cycle (target 0x40) -> Address=0x40 next cycle, IF flushed.
//  5 IMEM_DEPTH=4, no branches -> Address 0,4,8,12,0,4; IF_PCPlus4 after word 3 = 16.
//  6 mem[2]=HALT_WORD -> IF_Instruction=HALT_WORD once, Halted=1, Address frozen at 8,
//    FetchCount=3; Redirect to 0 clears Halted; Rst low in HALT -> all reset values.

Source files
------------

// File: rtl/instruction_fetch_controller_if.sv
// rtl/instruction_fetch_controller_if.sv - fetch controller bus: hazard/branch inputs, imem port, IF/ID outputs
interface instruction_fetch_controller_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] address;
    logic [31:0] instruction;
    logic [31:0] if_instruction;
    logic [31:0] if_pcplus4;
    logic        if_valid;
    logic        halted;
    logic [31:0] fetch_count;

    modport master (
        input  stall, redirect, redirect_pc, instruction,
        output address, if_instruction, if_pcplus4, if_valid, halted, fetch_count
    );

    modport slave (
        output stall, redirect, redirect_pc, instruction,
        input  address, if_instruction, if_pcplus4, if_valid, halted, fetch_count
    );
endinterface

// File: rtl/instruction_fetch_controller.sv
// rtl/instruction_fetch_controller.sv - PC sequencer and IF/ID register with stall, redirect, wrap and halt
module instruction_fetch_controller #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 128,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic                                clk,
    input  logic                                rst,
    instruction_fetch_controller_if.master      bus
);
    localparam logic [31:0] MEM_BYTES = 32'(4 * IMEM_DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, STALL, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifi_q, ifi_d;
    logic [31:0] ifp_q, ifp_d;
    logic [31:0] cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_plus4, next_seq, target;

    assign pc_plus4 = pc_q + 32'd4;
    assign next_seq = (pc_plus4 == MEM_BYTES) ? 32'd0 : pc_plus4;
    assign target   = (bus.redirect_pc & ~32'd3) % MEM_BYTES;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifi_d   = ifi_q;
        ifp_d   = ifp_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        case (state_q)
            BOOT: begin
                valid_d = 1'b0;
                state_d = RUN;
                if (bus.redirect) begin
                    pc_d  = target;
                    ifi_d = 32'd0;
                end
            end
            RUN, STALL: begin
                if (bus.redirect) begin
                    pc_d    = target;
                    ifi_d   = 32'd0;
                    valid_d = 1'b0;
                    state_d = RUN;
                end else if (bus.stall) begin
                    state_d = STALL;
                end else begin
                    // Leaving STALL fetches the held PC in this same cycle, so nothing is lost.
                    ifi_d   = bus.instruction;
                    ifp_d   = pc_plus4;
                    valid_d = 1'b1;
                    cnt_d   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
                    if (bus.instruction == HALT_WORD) begin
                        state_d = HALT;
                    end else begin
                        pc_d    = next_seq;
                        state_d = RUN;
                    end
                end
            end
            HALT: begin
                ifi_d   = 32'd0;
                valid_d = 1'b0;
                if (bus.redirect) begin
                    pc_d    = target;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            ifi_q   <= 32'd0;
            ifp_q   <= 32'd0;
            cnt_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifi_q   <= ifi_d;
            ifp_q   <= ifp_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign bus.address        = pc_q;
    assign bus.if_instruction = ifi_q;
    assign bus.if_pcplus4     = ifp_q;
    assign bus.if_valid       = valid_q;
    assign bus.halted         = (state_q == HALT);
    assign bus.fetch_count    = cnt_q;
endmodule
